// File: rtl/snake_body_engine.sv
// snake_body_engine: segment-array snake body, moved one cell per tick.
// Optional macro SNAKE_WALL_WRAP_EN: wrap at grid edges instead of wall death.
module snake_body_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 5,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [1:0]                   MASTER_STATE,
  input  logic [1:0]                   NAV_DIR,
  input  logic [COL_BITS-1:0]          FOOD_X,
  input  logic [ROW_BITS-1:0]          FOOD_Y,
  input  logic [COL_BITS-1:0]          QUERY_X,
  input  logic [ROW_BITS-1:0]          QUERY_Y,
  output logic [1:0]                   QUERY_HIT,
  output logic [COL_BITS-1:0]          HEAD_X,
  output logic [ROW_BITS-1:0]          HEAD_Y,
  output logic [$clog2(MAX_LEN+1)-1:0] LENGTH,
  output logic                         TARGET_REACHED,
  output logic                         COLLISION,
  output logic                         DEAD
);

  localparam int LEN_BITS = $clog2(MAX_LEN + 1);
  localparam int CNT_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_PLAY = 2'b01;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DEAD
  } state_t;

  state_t                state_q;
  logic [1:0]            dir_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [COL_BITS-1:0]   segx_q [MAX_LEN];
  logic [ROW_BITS-1:0]   segy_q [MAX_LEN];
  logic                  tr_q;
  logic                  col_q;
  logic                  dead_q;
  logic [1:0]            hit_q;

  logic                  force_init;
  logic                  play;
  logic                  run_en;
  logic                  tick;
  logic [1:0]            dir_d;
  logic [COL_BITS-1:0]   nx;
  logic [ROW_BITS-1:0]   ny;
  logic                  wall;
  logic                  food_hit;
  logic                  self_hit;
  logic                  collide;
  logic                  q_head;
  logic                  q_body;

  assign force_init = RESET || (MASTER_STATE == MS_IDLE);
  assign play       = (MASTER_STATE == MS_PLAY);
  // The first PLAY cycle out of S_INIT already counts toward the first tick.
  assign run_en     = play && (state_q != S_DEAD);
  assign tick       = run_en && (cnt_q == CNT_BITS'(TICK_DIV - 1));
  assign dir_d      = (NAV_DIR == (dir_q ^ 2'b10)) ? dir_q : NAV_DIR;

  // Next head position and edge handling for the chosen direction
  always_comb begin
    nx   = segx_q[0];
    ny   = segy_q[0];
    wall = 1'b0;
    unique case (dir_d)
      2'b00: begin
        if (segy_q[0] == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
          ny = ROW_BITS'(GRID_H - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          ny = segy_q[0] - ROW_BITS'(1);
        end
      end
      2'b01: begin
        if (segx_q[0] == COL_BITS'(GRID_W - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
          nx = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nx = segx_q[0] + COL_BITS'(1);
        end
      end
      2'b10: begin
        if (segy_q[0] == ROW_BITS'(GRID_H - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
          ny = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          ny = segy_q[0] + ROW_BITS'(1);
        end
      end
      2'b11: begin
        if (segx_q[0] == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
          nx = COL_BITS'(GRID_W - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nx = segx_q[0] - COL_BITS'(1);
        end
      end
    endcase
  end

  // Food and body collision against the next head; tail counts only on growth
  always_comb begin
    food_hit = !wall && (nx == FOOD_X) && (ny == FOOD_Y);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((i + 1 < int'(len_q)) ||
           (food_hit && (i + 1 == int'(len_q)))) &&
          (segx_q[i] == nx) && (segy_q[i] == ny)) begin
        self_hit = 1'b1;
      end
    end
    collide = wall || self_hit;
  end

  // Pixel-cell query against the active segments; head wins over body
  always_comb begin
    q_head = (segx_q[0] == QUERY_X) && (segy_q[0] == QUERY_Y);
    q_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) &&
          (segx_q[i] == QUERY_X) && (segy_q[i] == QUERY_Y)) begin
        q_body = 1'b1;
      end
    end
  end

  // Engine state machine: init, movement, growth, death and query register
  always_ff @(posedge CLK) begin
    tr_q  <= 1'b0;
    col_q <= 1'b0;
    if (force_init) begin
      state_q <= S_INIT;
      dir_q   <= 2'b01;
      cnt_q   <= '0;
      len_q   <= LEN_BITS'(INIT_LEN);
      dead_q  <= 1'b0;
      hit_q   <= 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
        segx_q[i] <= COL_BITS'(GRID_W / 2 -
                     ((i < INIT_LEN) ? i : INIT_LEN - 1));
        segy_q[i] <= ROW_BITS'(GRID_H / 2);
      end
    end else begin
      hit_q <= q_head ? 2'b01 : (q_body ? 2'b10 : 2'b00);
      if (state_q == S_INIT && play) begin
        state_q <= S_RUN;
      end
      if (run_en) begin
        if (tick) begin
          cnt_q <= '0;
          dir_q <= dir_d;
          if (collide) begin
            col_q   <= 1'b1;
            dead_q  <= 1'b1;
            state_q <= S_DEAD;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              segx_q[i] <= segx_q[i-1];
              segy_q[i] <= segy_q[i-1];
            end
            segx_q[0] <= nx;
            segy_q[0] <= ny;
            if (food_hit) begin
              tr_q <= 1'b1;
              if (len_q != LEN_BITS'(MAX_LEN)) begin
                len_q <= len_q + LEN_BITS'(1);
              end
            end
          end
        end else begin
          cnt_q <= cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

  assign QUERY_HIT      = hit_q;
  assign HEAD_X         = segx_q[0];
  assign HEAD_Y         = segy_q[0];
  assign LENGTH         = len_q;
  assign TARGET_REACHED = tr_q;
  assign COLLISION      = col_q;
  assign DEAD           = dead_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed scoreboard bench for snake_body_engine.
// Events (move/eat/collide) are queued by stimulus and checked by a monitor.
module tb_snake_body_engine;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int CB = 3;
  localparam int RB = 3;
  localparam int ML = 8;
  localparam int IL = 3;
  localparam int TD = 4;
  localparam int LB = $clog2(ML + 1);

  localparam logic [1:0] K_MOVE = 2'b00;
  localparam logic [1:0] K_EAT  = 2'b01;
  localparam logic [1:0] K_COL  = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ms;
  logic [1:0]    nav;
  logic [CB-1:0] fx;
  logic [RB-1:0] fy;
  logic [CB-1:0] qx;
  logic [RB-1:0] qy;
  logic [1:0]    qhit;
  logic [CB-1:0] hx;
  logic [RB-1:0] hy;
  logic [LB-1:0] len;
  logic          tr;
  logic          col;
  logic          dead;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    kind;
    logic [CB-1:0] x;
    logic [RB-1:0] y;
    int            len;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic          mon_en = 1'b0;
  logic [CB-1:0] px;
  logic [RB-1:0] py;
  logic [CB-1:0] cur_x;
  logic [RB-1:0] cur_y;

  always #5 clk = ~clk;

  snake_body_engine #(
    .GRID_W(GW), .GRID_H(GH), .COL_BITS(CB), .ROW_BITS(RB),
    .MAX_LEN(ML), .INIT_LEN(IL), .TICK_DIV(TD)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .MASTER_STATE(ms),
    .NAV_DIR(nav),
    .FOOD_X(fx),
    .FOOD_Y(fy),
    .QUERY_X(qx),
    .QUERY_Y(qy),
    .QUERY_HIT(qhit),
    .HEAD_X(hx),
    .HEAD_Y(hy),
    .LENGTH(len),
    .TARGET_REACHED(tr),
    .COLLISION(col),
    .DEAD(dead)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [CB-1:0] x,
                           input logic [RB-1:0] y, input int l);
    ev_t e;
    e.kind = k;
    e.x    = x;
    e.y    = y;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // One full tick period: query check after edge 1, head check before edge 4
  task automatic tick(input logic [1:0] d, input logic [CB-1:0] fxv,
                      input logic [RB-1:0] fyv, input logic [1:0] k,
                      input logic [CB-1:0] ex, input logic [RB-1:0] ey,
                      input int el, input int qexp);
    nav = d;
    fx  = fxv;
    fy  = fyv;
    @(posedge clk);
    @(negedge clk);
    if (qexp >= 0) chk("query_hit", qhit, qexp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("head_before_tick", {hx, hy}, {cur_x, cur_y});
    expect_ev(k, ex, ey, el);
    cur_x = ex;
    cur_y = ey;
    @(posedge clk);
    #1;
  endtask

  // Monitor: any head change or pulse is a DUT event matched to the queue
  always @(negedge clk) begin
    if (mon_en && (hx !== px || hy !== py || tr || col)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: head %0d,%0d tr %0d col %0d",
                 hx, hy, tr, col);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_kind", {col, tr}, mon_e.kind);
        chk("ev_head", {hx, hy}, {mon_e.x, mon_e.y});
        chk("ev_len", len, mon_e.len);
        chk("ev_dead", dead, mon_e.kind == K_COL);
      end
    end
    px = hx;
    py = hy;
  end

  task automatic go_idle();
    mon_en = 1'b0;
    ms     = 2'b00;
    cyc(2);
    @(negedge clk);
    chk("idle_head", {hx, hy}, {3'd4, 3'd4});
    chk("idle_len", len, IL);
    chk("idle_dead", dead, 0);
    chk("idle_query", qhit, 0);
    cur_x  = 3'd4;
    cur_y  = 3'd4;
    ms     = 2'b01;
    mon_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    ms    = 2'b00;
    nav   = 2'b01;
    fx    = 3'd0;
    fy    = 3'd7;
    qx    = 3'd2;
    qy    = 3'd4;
    cur_x = 3'd4;
    cur_y = 3'd4;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("rst_head_x", hx, 4);
    chk("rst_head_y", hy, 4);
    chk("rst_len", len, IL);
    chk("rst_dead", dead, 0);
    chk("rst_query", qhit, 0);
    chk("rst_pulses", {tr, col}, 0);

    // Basic move, query latency, growth, reversal, wall
    ms     = 2'b01;
    mon_en = 1'b1;
    tick(2'b01, 3'd0, 3'd7, K_MOVE, 3'd5, 3'd4, 3, 2);
    tick(2'b01, 3'd6, 3'd4, K_EAT, 3'd6, 3'd4, 4, 0);
    qx = 3'd3;
    tick(2'b11, 3'd0, 3'd7, K_MOVE, 3'd7, 3'd4, 4, 2);
    qx = 3'd7;
`ifdef SNAKE_WALL_WRAP_EN
    tick(2'b01, 3'd0, 3'd4, K_EAT, 3'd0, 3'd4, 5, 1);
`else
    tick(2'b01, 3'd0, 3'd4, K_COL, 3'd7, 3'd4, 4, 1);
    cyc(4);
    @(negedge clk);
    chk("wall_dead_hold", dead, 1);
`endif
    go_idle();

    // Self-collision after growing to five
    tick(2'b01, 3'd5, 3'd4, K_EAT, 3'd5, 3'd4, 4, -1);
    tick(2'b01, 3'd6, 3'd4, K_EAT, 3'd6, 3'd4, 5, -1);
    tick(2'b00, 3'd0, 3'd7, K_MOVE, 3'd6, 3'd3, 5, -1);
    tick(2'b11, 3'd0, 3'd7, K_MOVE, 3'd5, 3'd3, 5, -1);
    tick(2'b10, 3'd0, 3'd7, K_COL, 3'd5, 3'd3, 5, -1);
    cyc(8);
    @(negedge clk);
    chk("self_dead_hold", dead, 1);
    chk("self_head_frozen", {hx, hy}, {3'd5, 3'd3});
    go_idle();

    // Grow to MAX_LEN, eat at saturation, then WIN freeze mid-count
    tick(2'b01, 3'd5, 3'd4, K_EAT, 3'd5, 3'd4, 4, -1);
    tick(2'b01, 3'd6, 3'd4, K_EAT, 3'd6, 3'd4, 5, -1);
    tick(2'b01, 3'd7, 3'd4, K_EAT, 3'd7, 3'd4, 6, -1);
    tick(2'b10, 3'd7, 3'd5, K_EAT, 3'd7, 3'd5, 7, -1);
    tick(2'b11, 3'd6, 3'd5, K_EAT, 3'd6, 3'd5, 8, -1);
    tick(2'b11, 3'd5, 3'd5, K_EAT, 3'd5, 3'd5, 8, -1);
    qx = 3'd3;
    qy = 3'd4;
    tick(2'b11, 3'd0, 3'd7, K_MOVE, 3'd4, 3'd5, 8, 2);
    cyc(2);
    ms  = 2'b10;
    nav = 2'b10;
    cyc(20);
    @(negedge clk);
    chk("win_head_frozen", {hx, hy}, {3'd4, 3'd5});
    chk("win_len", len, 8);
    ms  = 2'b01;
    nav = 2'b11;
    cyc(1);
    @(negedge clk);
    chk("resume_pre_tick", {hx, hy}, {3'd4, 3'd5});
    expect_ev(K_MOVE, 3'd3, 3'd5, 8);
    cyc(1);
    @(negedge clk);
    chk("resume_tick_head", {hx, hy}, {3'd3, 3'd5});
    cyc(2);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised successor to the game's snake controller. Holds the full snake body as a segment array on a cell grid and advances it one cell per movement tick.
- Grows the snake on food, detects self-collision (and wall collision when wrap is off), and answers per-pixel cell queries from the VGA path.
- Sits between the master state machine / navigation SM / target generator and the VGA colour logic.

Parameters:
- GRID_W, 40, grid columns (640 px / 16 px cells).
- GRID_H, 30, grid rows.
- COL_BITS, 6, width of column coordinates; must satisfy 2^COL_BITS >= GRID_W.
- ROW_BITS, 5, width of row coordinates; must satisfy 2^ROW_BITS >= GRID_H.
- MAX_LEN, 32, segment array depth (maximum snake length).
- INIT_LEN, 4, length after reset or in IDLE; must satisfy 2 <= INIT_LEN <= MAX_LEN.
- TICK_DIV, 25000000, CLK cycles per movement tick (0.25 s at 100 MHz).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- MASTER_STATE  in  2  00 IDLE, 01 PLAY, 10 WIN (11 treated as WIN)
- NAV_DIR  in  2  00 up, 01 right, 10 down, 11 left
- FOOD_X  in  COL_BITS  food column
- FOOD_Y  in  ROW_BITS  food row
- QUERY_X  in  COL_BITS  cell column being drawn
- QUERY_Y  in  ROW_BITS  cell row being drawn
- QUERY_HIT  out  2  bit0 = query cell is the head; bit1 = query cell is a body segment; registered
- HEAD_X  out  COL_BITS  current head column
- HEAD_Y  out  ROW_BITS  current head row
- LENGTH  out  $clog2(MAX_LEN+1)  current length
- TARGET_REACHED  out  1  one-cycle pulse when the head lands on food
- COLLISION  out  1  one-cycle pulse on death
- DEAD  out  1  level; high while the engine is in S_DEAD

Behaviour:
- Internal states: S_INIT, S_RUN, S_DEAD.
- RESET, or MASTER_STATE == IDLE, forces S_INIT every cycle. In S_INIT:
  - Head at (GRID_W/2, GRID_H/2); segment i at (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN.
  - Direction = right; LENGTH = INIT_LEN; tick counter = 0.
  - TARGET_REACHED = 0, COLLISION = 0, DEAD = 0, QUERY_HIT = 00.
- S_INIT -> S_RUN on the first cycle that MASTER_STATE == PLAY.
- Tick counter increments only in S_RUN while MASTER_STATE == PLAY. The tick fires when count == TICK_DIV-1; count then returns to 0.
- WIN, or any non-PLAY state entered while in S_RUN: body, direction and counter freeze. Movement resumes on return to PLAY.
- On each tick cycle:
  - NAV_DIR is sampled. A 180-degree reversal of the current direction is ignored (current direction kept).
  - Next head = head ±1 in the chosen direction, with edge handling per the optional feature.
  - Collision: next head equals any active segment 0..LENGTH-2. The tail segment is excluded unless growing this tick.
  - Growth: next head == (FOOD_X, FOOD_Y).
- Registered result, visible the cycle after the tick:
  - Collision: COLLISION pulses 1 cycle; state -> S_DEAD; body not moved; no TARGET_REACHED even if food coincides (collision wins).
  - Otherwise: segments shift (seg[i] <= seg[i-1]) and seg[0] <= next head.
  - If growth: TARGET_REACHED pulses 1 cycle, and LENGTH increments, saturating at MAX_LEN. At MAX_LEN the pulse still fires and the tail is dropped as for a normal move.
- S_DEAD holds the body frozen until S_INIT is forced (RESET or IDLE). DEAD = 1 in S_DEAD.
- QUERY_HIT has 1-cycle latency. It compares against segments 0..LENGTH-1 only; segments >= LENGTH are never reported. bit0 and bit1 are mutually exclusive; head wins.
- HEAD_X/HEAD_Y mirror seg[0] with no extra latency.

Optional Feature:
- Macro: SNAKE_WALL_WRAP_EN.
- Defined: next head wraps at the edges. Column GRID_W-1 -> 0 and 0 -> GRID_W-1; rows likewise with GRID_H.
- Undefined: a next head outside 0..GRID_W-1 / 0..GRID_H-1 is a collision (COLLISION pulse, S_DEAD), with the same priority over food as self-collision.

Test Plan:
- Bench parameters: TICK_DIV=4, GRID_W=8, GRID_H=8, MAX_LEN=8, INIT_LEN=3.
- RESET, then PLAY with NAV_DIR=01 -> head (4,4) becomes (5,4) exactly 1 cycle after the 4th PLAY cycle; LENGTH stays 3; QUERY (2,4) -> 10 before the tick, 00 one cycle after the update.
- Food at (5,4), right move -> TARGET_REACHED high for exactly 1 cycle; LENGTH 3 -> 4; tail (2,4) retained.
- Head moving right, NAV_DIR=11 (left) at the tick -> reversal ignored; head still moves right.
- Self-collision: grow to LENGTH 5, then steer up, left, down into the body -> COLLISION 1-cycle pulse, DEAD=1, HEAD frozen. MASTER_STATE=IDLE -> DEAD=0, head back at (4,4), LENGTH 3.
- Head at (7,4) moving right with food at (0,4):
  - With SNAKE_WALL_WRAP_EN: head -> (0,4), TARGET_REACHED=1.
  - Without it: COLLISION=1, no TARGET_REACHED.
- Grow to LENGTH 8 (MAX_LEN), eat again -> TARGET_REACHED pulses, LENGTH stays 8. MASTER_STATE=WIN mid-count -> no movement for 20 cycles; resume PLAY -> next tick continues from the held count.
